karatsuba_seq: RTL and testbench



---
 rtl/karatsuba_seq_pkg.sv | 19 +
 rtl/karatsuba_seq_core.sv | 17 +
 rtl/karatsuba_seq.sv | 197 +++++++++++++++++++
 tb/tb_karatsuba_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/karatsuba_seq_pkg.sv
// Shared types and constants for the sequential Karatsuba multiplier.
//   kseq_state_t : FSM encoding (IDLE, MUL_H, MUL_L, MUL_M, COMB, DONE)
//   KSEQ_LAT     : accept-to-valid latency, core output unregistered
//   KSEQ_LAT_REG : accept-to-valid latency with KARATSUBA_SEQ_CORE_REG_EN
package karatsuba_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_H = 3'd1,
        MUL_L = 3'd2,
        MUL_M = 3'd3,
        COMB  = 3'd4,
        DONE  = 3'd5
    } kseq_state_t;

    localparam int unsigned KSEQ_LAT     = 4;
    localparam int unsigned KSEQ_LAT_REG = 7;

endpackage

// File: rtl/karatsuba_seq_core.sv
// kmul_core: combinational unsigned W x W -> 2W multiplier shared by the
// three Karatsuba sub-products.
//   a, b : W-bit unsigned operands
//   p    : 2W-bit product
module kmul_core #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    localparam int unsigned PW = 2 * W;

    assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/karatsuba_seq.sv
// Sequential valid/ready Karatsuba multiplier: one half-width core is reused
// for Ah*Bh, Al*Bl and |Al-Ah|*|Bh-Bl|, then the three products are combined
// into the exact 2N-bit result.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   in_a, in_b          : N-bit unsigned operands
//   out_valid/out_ready : result handshake (held until accepted)
//   out_c               : 2N-bit product
//   busy                : FSM outside IDLE
// Build option: define KARATSUBA_SEQ_CORE_REG_EN to register the core output;
// each MUL state then takes two cycles (latency 7, interval 9).
module karatsuba_seq
    import karatsuba_seq_pkg::*;
#(
    parameter int unsigned N = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_c,
    output logic           busy
);

    localparam int unsigned H  = N / 2;
    localparam int unsigned CW = 2 * N;
    localparam int unsigned MW = N + 2;

    generate
        if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
            $error("karatsuba_seq: N must be a power of 2 and at least 2");
        end
    endgenerate

    kseq_state_t  state_q, state_nxt;
    logic [N-1:0] a_q, b_q;
    logic [H-1:0] am_q, bm_q;
    logic         s_q;
    logic [N-1:0] p3_q, p2_q, p1_q;

    logic         accept, ld_p3, ld_p2, ld_p1, ld_c;
    logic         core_done;
    logic [H-1:0] core_a, core_b;
    logic [N-1:0] core_p, prod;

    // Half differences at H+1 bits; bit H is the sign, magnitude fits in H bits
    logic [H:0]   diff_a, diff_b;
    logic [H-1:0] mag_a, mag_b;

    always_comb begin
        diff_a = {1'b0, in_a[H-1:0]} - {1'b0, in_a[N-1:H]};
        diff_b = {1'b0, in_b[N-1:H]} - {1'b0, in_b[H-1:0]};
        mag_a  = diff_a[H] ? (H'(0) - diff_a[H-1:0]) : diff_a[H-1:0];
        mag_b  = diff_b[H] ? (H'(0) - diff_b[H-1:0]) : diff_b[H-1:0];
    end

    kmul_core #(.W(H)) u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

`ifdef KARATSUBA_SEQ_CORE_REG_EN
    // Core output stage; phase_q marks the second cycle of a MUL state
    logic [N-1:0] core_q;
    logic         phase_q, phase_nxt;

    assign phase_nxt = (state_q == MUL_H || state_q == MUL_L || state_q == MUL_M) && !phase_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            core_q  <= core_p;
            phase_q <= phase_nxt;
        end
    end

    assign prod      = core_q;
    assign core_done = phase_q;
`else
    assign prod      = core_p;
    assign core_done = 1'b1;
`endif

    // Middle term is non-negative by construction; top bit of mid is always 0
    logic [MW-1:0] mid_sum, mid;
    logic [CW-1:0] comb_c;

    always_comb begin
        mid_sum = MW'(p3_q) + MW'(p2_q);
        mid     = s_q ? (mid_sum - MW'(p1_q)) : (mid_sum + MW'(p1_q));
        comb_c  = {p3_q, p2_q} + (CW'(mid) << H);
    end

    // Next-state, load enables and core operand select
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        ld_p3     = 1'b0;
        ld_p2     = 1'b0;
        ld_p1     = 1'b0;
        ld_c      = 1'b0;
        core_a    = '0;
        core_b    = '0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    accept    = 1'b1;
                    state_nxt = MUL_H;
                end
            end
            MUL_H: begin
                core_a = a_q[N-1:H];
                core_b = b_q[N-1:H];
                if (core_done) begin
                    ld_p3     = 1'b1;
                    state_nxt = MUL_L;
                end
            end
            MUL_L: begin
                core_a = a_q[H-1:0];
                core_b = b_q[H-1:0];
                if (core_done) begin
                    ld_p2     = 1'b1;
                    state_nxt = MUL_M;
                end
            end
            MUL_M: begin
                core_a = am_q;
                core_b = bm_q;
                if (core_done) begin
                    ld_p1     = 1'b1;
                    state_nxt = COMB;
                end
            end
            COMB: begin
                ld_c      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

    // Operand, sub-product and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            am_q  <= '0;
            bm_q  <= '0;
            s_q   <= 1'b0;
            p3_q  <= '0;
            p2_q  <= '0;
            p1_q  <= '0;
            out_c <= '0;
        end else begin
            if (accept) begin
                a_q  <= in_a;
                b_q  <= in_b;
                am_q <= mag_a;
                bm_q <= mag_b;
                s_q  <= diff_a[H] ^ diff_b[H];
            end
            if (ld_p3) p3_q  <= prod;
            if (ld_p2) p2_q  <= prod;
            if (ld_p1) p1_q  <= prod;
            if (ld_c)  out_c <= comb_c;
        end
    end

endmodule

// File: tb/tb_karatsuba_seq.sv
// Bench for karatsuba_seq: an N=8 instance for directed cases (corner operands,
// backpressure, reset mid-operation) and an N=64 instance for a 1000-pair
// stream. Expected products are queued on accept and compared on output.
// Honors KARATSUBA_SEQ_CORE_REG_EN for the latency/interval expectations.
module tb_karatsuba_seq;

`ifdef KARATSUBA_SEQ_CORE_REG_EN
    localparam int EXP_LAT = 7;
    localparam int EXP_II  = 9;
`else
    localparam int EXP_LAT = 4;
    localparam int EXP_II  = 6;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // N = 8 instance
    logic        v8, ir8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] c8;

    karatsuba_seq #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .in_ready  (ir8),
        .in_a      (a8),
        .in_b      (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .out_c     (c8),
        .busy      (busy8)
    );

    // N = 64 instance
    logic         v64, ir64, ov64, or64, busy64;
    logic [63:0]  a64, b64;
    logic [127:0] c64;

    karatsuba_seq #(.N(64)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v64),
        .in_ready  (ir64),
        .in_a      (a64),
        .in_b      (b64),
        .out_valid (ov64),
        .out_ready (or64),
        .out_c     (c64),
        .busy      (busy64)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboards
    logic [15:0]  q8[$];
    logic [127:0] q64[$];
    int   acc8       = 0;
    int   last_acc64 = -1;
    logic ov8_d      = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (v8 && ir8) begin
                q8.push_back(16'(a8) * 16'(b8));
                acc8 = cyc + 1;
            end
            if (ov8 && !ov8_d) check("lat8", 128'(cyc - acc8), 128'(EXP_LAT));
            if (ov8 && or8) begin
                if (q8.size() == 0) check("spurious8", 128'(ov8), 128'(0));
                else                check("prod8", 128'(c8), 128'(q8.pop_front()));
            end
        end
        ov8_d = ov8;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (v64 && ir64) begin
                q64.push_back(128'(a64) * 128'(b64));
                if (last_acc64 >= 0) check("ii64", 128'(cyc - last_acc64), 128'(EXP_II));
                last_acc64 = cyc;
            end
            if (ov64 && or64) begin
                if (q64.size() == 0) check("spurious64", 128'(ov64), 128'(0));
                else                 check("prod64", 128'(c64), 128'(q64.pop_front()));
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(posedge clk); #1;
        a8 = a;
        b8 = b;
        v8 = 1'b1;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ir8 && n < 50);
        check("rdy8", 128'(ir8), 128'(1));
        @(posedge clk); #1;
        v8 = 1'b0;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (q8.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain8", 128'(q8.size()), 128'(0));
    endtask

    task automatic set_ops64(input int k);
        case (k)
            0:       begin a64 = '1;             b64 = '1;             end
            1:       begin a64 = 64'h8000_0000_0000_0000; b64 = 64'h8000_0000_0000_0000; end
            2:       begin a64 = '0;             b64 = {$urandom, $urandom}; end
            3:       begin a64 = '1;             b64 = 64'd1;          end
            4:       begin a64 = 64'h0000_0000_FFFF_FFFF; b64 = 64'hFFFF_FFFF_0000_0000; end
            default: begin a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; end
        endcase
    endtask

    logic [7:0]  ta [8];
    logic [7:0]  tb [8];
    logic [15:0] bp_exp;

    initial begin
        int n;
        int acc;
        rst_n = 1'b0;
        v8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        v64 = 1'b0; or64 = 1'b0; a64 = '0; b64 = '0;
        ta = '{8'hFF, 8'h3C, 8'h00, 8'h01, 8'hFF, 8'h80, 8'hA5, 8'h0F};
        tb = '{8'hFF, 8'h5A, 8'hAB, 8'hAB, 8'h01, 8'h80, 8'h5A, 8'hF0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ov8",   128'(ov8),   128'(0));
        check("rst_busy8", 128'(busy8), 128'(0));
        check("rst_c8",    128'(c8),    128'(0));
        check("rst_c64",   c64,         128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ir8",  128'(ir8),  128'(1));
        check("rst_ir64", 128'(ir64), 128'(1));

        // Directed N=8 operands, out_ready high
        or8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send8(ta[i], tb[i]);
            drain8();
        end

        // Backpressure: hold the result in DONE, in_valid must be ignored
        @(posedge clk); #1;
        or8    = 1'b0;
        bp_exp = 16'(8'hC3) * 16'(8'h7E);
        send8(8'hC3, 8'h7E);
        n = 0;
        while (!ov8 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", 128'(ov8), 128'(1));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            v8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            @(negedge clk);
            check("bp_ov",   128'(ov8),   128'(1));
            check("bp_c",    128'(c8),    128'(bp_exp));
            check("bp_ir",   128'(ir8),   128'(0));
            check("bp_busy", 128'(busy8), 128'(1));
        end
        @(posedge clk); #1;
        v8  = 1'b0;
        or8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_ov_after",   128'(ov8),       128'(0));
        check("bp_ir_after",   128'(ir8),       128'(1));
        check("bp_busy_after", 128'(busy8),     128'(0));
        check("bp_queue",      128'(q8.size()), 128'(0));

        // Reset while in MUL_L
        send8(8'h55, 8'h66);
        @(posedge clk);
`ifdef KARATSUBA_SEQ_CORE_REG_EN
        @(posedge clk);
`endif
        @(negedge clk);
        check("mid_busy", 128'(busy8), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_ov",   128'(ov8),   128'(0));
        check("mid_busy0", 128'(busy8), 128'(0));
        check("mid_c",    128'(c8),    128'(0));
        q8.delete();
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_ir", 128'(ir8), 128'(1));
        repeat (12) @(negedge clk);
        send8(8'h55, 8'h66);
        drain8();

        // N=64 stream: in_valid held high, out_ready high
        @(posedge clk); #1;
        or64 = 1'b1;
        set_ops64(0);
        v64 = 1'b1;
        acc = 0;
        n   = 0;
        while (acc < 1000 && n < 12000) begin
            @(negedge clk);
            n++;
            if (ir64) begin
                acc++;
                @(posedge clk); #1;
                if (acc < 1000) set_ops64(acc);
                else            v64 = 1'b0;
            end
        end
        check("stream_cnt", 128'(acc), 128'(1000));
        n = 0;
        while (q64.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain64", 128'(q64.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
